// File: rtl/memory_access_if.sv
// Data-bus request/response bundle between the memory stage (master) and the data memory port (slave).
interface memory_access_if;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;

   modport master (
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_addr_ok, dresp_data_ok, dresp_data
   );

   modport slave (
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_addr_ok, dresp_data_ok, dresp_data
   );
endinterface

// File: rtl/memory_access.sv
// Memory stage: issues load/store bus transactions, aligns/extends load data, registers the writeback result.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module memory_access (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [63:0]     in_aluout,
   input  logic [63:0]     in_wdata,
   input  logic            in_memread,
   input  logic            in_memwrite,
   input  logic [1:0]      in_msize,
   input  logic            in_unsigned,
   input  logic [4:0]      in_rd,
   input  logic            in_regwrite,
   input  logic [63:0]     in_pc,
   input  logic            flush,
   memory_access_if.master dbus,
   output logic            stall_m,
   output logic            out_valid,
   output logic            out_regwrite,
   output logic            out_misalign,
   output logic [63:0]     out_result,
   output logic [4:0]      out_rd,
   output logic [63:0]     out_pc
);

   typedef enum logic [1:0] {IDLE, WAIT_DATA, DONE} state_t;
   typedef enum logic [1:0] {CAP_BUBBLE, CAP_PASS, CAP_MEM} cap_t;

   state_t      state, state_next;
   cap_t        cap_sel;
   logic        dreq_valid_c;
   logic        take_data;
   logic        kill_q;
   logic [63:0] rdata_q;

   logic [2:0]  off;
   logic [5:0]  lane_shift;
   logic        mem_op;
   logic        live_in;
   logic        trap;
   logic        req_go;
   logic [7:0]  size_mask;
   logic [7:0]  strobe_c;
   logic [63:0] sh;
   logic [63:0] load_val;
   logic        sext;

   assign off        = in_aluout[2:0];
   assign lane_shift = {off, 3'b000};
   assign mem_op     = in_memread | in_memwrite;
   assign live_in    = in_valid & ~flush;

`ifdef MEM_MISALIGN_TRAP_EN
   logic misaligned;

   always_comb begin
      misaligned = 1'b0;
      unique case (in_msize)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = off[0];
         2'b10:   misaligned = |off[1:0];
         2'b11:   misaligned = |off;
         default: misaligned = 1'b0;
      endcase
   end

   assign trap = live_in & mem_op & misaligned;
`else
   assign trap = 1'b0;
`endif

   assign req_go = live_in & mem_op & ~trap;

   always_comb begin
      size_mask = 8'h01;
      unique case (in_msize)
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         2'b11:   size_mask = 8'hFF;
         default: size_mask = 8'h01;
      endcase
   end

   // Lanes shifted past bit 7 / bit 63 fall off, which drops bytes crossing the dword boundary.
   assign strobe_c = in_memwrite ? (size_mask << off) : 8'h00;

   assign dbus.dreq_valid  = dreq_valid_c;
   assign dbus.dreq_addr   = in_aluout;
   assign dbus.dreq_size   = {1'b0, in_msize};
   assign dbus.dreq_strobe = strobe_c;
   assign dbus.dreq_data   = in_wdata << lane_shift;

   assign sh   = rdata_q >> lane_shift;
   assign sext = ~in_unsigned;

   always_comb begin
      load_val = sh;
      unique case (in_msize)
         2'b00:   load_val = {{56{sext & sh[7]}},  sh[7:0]};
         2'b01:   load_val = {{48{sext & sh[15]}}, sh[15:0]};
         2'b10:   load_val = {{32{sext & sh[31]}}, sh[31:0]};
         2'b11:   load_val = sh;
         default: load_val = sh;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (req_go) begin
               if (dbus.dresp_addr_ok && dbus.dresp_data_ok) state_next = DONE;
               else if (dbus.dresp_addr_ok)                  state_next = WAIT_DATA;
               else                                          state_next = IDLE;
            end
         end
         WAIT_DATA: if (dbus.dresp_data_ok) state_next = DONE;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // While stalled the output register takes a bubble so writeback never sees a duplicate.
   always_comb begin
      dreq_valid_c = 1'b0;
      stall_m      = 1'b0;
      take_data    = 1'b0;
      cap_sel      = CAP_BUBBLE;
      unique case (state)
         IDLE: begin
            if (req_go) begin
               dreq_valid_c = 1'b1;
               stall_m      = 1'b1;
               take_data    = dbus.dresp_addr_ok & dbus.dresp_data_ok;
            end else begin
               cap_sel = CAP_PASS;
            end
         end
         WAIT_DATA: begin
            stall_m   = 1'b1;
            take_data = dbus.dresp_data_ok;
         end
         DONE:    cap_sel = CAP_MEM;
         default: cap_sel = CAP_BUBBLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          rdata_q <= 64'h0;
      else if (take_data) rdata_q <= dbus.dresp_data;
   end

   // The bus cannot cancel an accepted request, so a flush while waiting is remembered until DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                               kill_q <= 1'b0;
      else if (state == WAIT_DATA && flush)    kill_q <= 1'b1;
      else if (state == DONE)                  kill_q <= 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_regwrite <= 1'b0;
         out_misalign <= 1'b0;
         out_result   <= 64'h0;
         out_rd       <= 5'd0;
         out_pc       <= 64'h0;
      end else begin
         unique case (cap_sel)
            CAP_PASS: begin
               out_valid    <= live_in;
               out_regwrite <= live_in & in_regwrite & ~trap;
               out_misalign <= trap;
               out_result   <= in_aluout;
               out_rd       <= in_rd;
               out_pc       <= in_pc;
            end
            CAP_MEM: begin
               out_valid    <= in_valid & ~flush & ~kill_q;
               out_regwrite <= in_valid & ~flush & ~kill_q & in_regwrite;
               out_misalign <= 1'b0;
               out_result   <= in_memread ? load_val : in_aluout;
               out_rd       <= in_rd;
               out_pc       <= in_pc;
            end
            default: begin
               out_valid    <= 1'b0;
               out_regwrite <= 1'b0;
               out_misalign <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access: ALU pass-through, loads, stores, flush, reset mid-transaction.
module tb_memory_access;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [63:0] in_aluout;
   logic [63:0] in_wdata;
   logic        in_memread;
   logic        in_memwrite;
   logic [1:0]  in_msize;
   logic        in_unsigned;
   logic [4:0]  in_rd;
   logic        in_regwrite;
   logic [63:0] in_pc;
   logic        flush;
   logic        stall_m;
   logic        out_valid;
   logic        out_regwrite;
   logic        out_misalign;
   logic [63:0] out_result;
   logic [4:0]  out_rd;
   logic [63:0] out_pc;

   int          checks;
   int          errors;
   int          stalls;
   int          reqs;
   logic [63:0] seen_addr;
   logic [7:0]  seen_strobe;
   logic [63:0] seen_data;
   logic [2:0]  seen_size;

   memory_access_if bus ();

   memory_access dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_aluout    (in_aluout),
      .in_wdata     (in_wdata),
      .in_memread   (in_memread),
      .in_memwrite  (in_memwrite),
      .in_msize     (in_msize),
      .in_unsigned  (in_unsigned),
      .in_rd        (in_rd),
      .in_regwrite  (in_regwrite),
      .in_pc        (in_pc),
      .flush        (flush),
      .dbus         (bus.master),
      .stall_m      (stall_m),
      .out_valid    (out_valid),
      .out_regwrite (out_regwrite),
      .out_misalign (out_misalign),
      .out_result   (out_result),
      .out_rd       (out_rd),
      .out_pc       (out_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic mr, input logic mw, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                                input logic rw, input logic [63:0] pc);
      in_valid    = 1'b1;
      in_memread  = mr;
      in_memwrite = mw;
      in_msize    = size;
      in_unsigned = uns;
      in_aluout   = addr;
      in_wdata    = wdata;
      in_rd       = rd;
      in_regwrite = rw;
      in_pc       = pc;
   endtask

   task automatic clearInput();
      in_valid    = 1'b0;
      in_memread  = 1'b0;
      in_memwrite = 1'b0;
      in_msize    = 2'b00;
      in_unsigned = 1'b0;
      in_aluout   = 64'h0;
      in_wdata    = 64'h0;
      in_rd       = 5'd0;
      in_regwrite = 1'b0;
      in_pc       = 64'h0;
   endtask

   // Called at a negedge with inputs applied; addr_ok on the first cycle, data_ok data_delay cycles later.
   // Returns at the negedge after the output register captured the result.
   task automatic runMemOp(input int data_delay, output int stall_cnt, output int req_cnt);
      bit done;
      done      = 1'b0;
      stall_cnt = 0;
      req_cnt   = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         bus.dresp_addr_ok = (k == 0);
         bus.dresp_data_ok = (k == data_delay);
         #1;
         if (k == 0) begin
            seen_addr   = bus.dreq_addr;
            seen_strobe = bus.dreq_strobe;
            seen_data   = bus.dreq_data;
            seen_size   = bus.dreq_size;
         end
         if (bus.dreq_valid) req_cnt++;
         if (!stall_m) done = 1'b1;
         else begin
            stall_cnt++;
            @(negedge clk);
         end
      end
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      if (!done) checkOutput("mem_op_timeout", 64'd0, 64'd1);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      flush  = 1'b0;
      clearInput();
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data    = 64'h0;
      repeat (2) @(negedge clk);

      checkOutput("rst_out_valid",    {63'd0, out_valid},    64'd0);
      checkOutput("rst_out_result",   out_result,            64'd0);
      checkOutput("rst_out_rd",       {59'd0, out_rd},       64'd0);
      checkOutput("rst_out_regwrite", {63'd0, out_regwrite}, 64'd0);
      checkOutput("rst_out_pc",       out_pc,                64'd0);
      checkOutput("rst_out_misalign", {63'd0, out_misalign}, 64'd0);
      checkOutput("rst_dreq_valid",   {63'd0, bus.dreq_valid}, 64'd0);
      checkOutput("rst_stall",        {63'd0, stall_m},      64'd0);
      reset = 1'b0;
      @(negedge clk);

      // ADD: one-edge pass-through, no stall
      applyStimulus(1'b0, 1'b0, 2'b11, 1'b0, 64'h1234, 64'h0, 5'd5, 1'b1, 64'h100);
      #1;
      checkOutput("add_stall", {63'd0, stall_m}, 64'd0);
      checkOutput("add_noreq", {63'd0, bus.dreq_valid}, 64'd0);
      @(negedge clk);
      checkOutput("add_result", out_result, 64'h1234);
      checkOutput("add_rd",     {59'd0, out_rd}, 64'd5);
      checkOutput("add_valid",  {63'd0, out_valid}, 64'd1);
      checkOutput("add_pc",     out_pc, 64'h100);
      clearInput();

      // LB signed, zero-wait bus
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 64'h1003, 64'h0, 5'd6, 1'b1, 64'h104);
      bus.dresp_data = 64'h0000_0000_8000_0000;
      runMemOp(0, stalls, reqs);
      checkOutput("lb_stall_cycles", 64'(stalls), 64'd1);
      checkOutput("lb_req_cycles",   64'(reqs), 64'd1);
      checkOutput("lb_addr",         seen_addr, 64'h1003);
      checkOutput("lb_strobe",       {56'd0, seen_strobe}, 64'h0);
      checkOutput("lb_result",       out_result, 64'hFFFF_FFFF_FFFF_FF80);
      checkOutput("lb_regwrite",     {63'd0, out_regwrite}, 64'd1);
      clearInput();

      // LBU same case
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 64'h1003, 64'h0, 5'd6, 1'b1, 64'h108);
      runMemOp(0, stalls, reqs);
      checkOutput("lbu_stall_cycles", 64'(stalls), 64'd1);
      checkOutput("lbu_result",       out_result, 64'h80);
      clearInput();

      // SW with 3 wait cycles on data_ok
      applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 64'h2004, 64'hDEADBEEF, 5'd0, 1'b0, 64'h10C);
      runMemOp(3, stalls, reqs);
      checkOutput("sw_stall_cycles", 64'(stalls), 64'd4);
      checkOutput("sw_req_cycles",   64'(reqs), 64'd1);
      checkOutput("sw_strobe",       {56'd0, seen_strobe}, 64'hF0);
      checkOutput("sw_data",         seen_data, 64'hDEADBEEF_0000_0000);
      checkOutput("sw_size",         {61'd0, seen_size}, 64'd2);
      checkOutput("sw_result",       out_result, 64'h2004);
      checkOutput("sw_valid",        {63'd0, out_valid}, 64'd1);
      checkOutput("sw_regwrite",     {63'd0, out_regwrite}, 64'd0);
      clearInput();

      // SB into the top lane
      applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 64'h2007, 64'hAB, 5'd0, 1'b0, 64'h110);
      runMemOp(0, stalls, reqs);
      checkOutput("sb_strobe", {56'd0, seen_strobe}, 64'h80);
      checkOutput("sb_data",   seen_data, 64'hAB00_0000_0000_0000);
      clearInput();

      // LD at a word-aligned but dword-misaligned address
      applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 64'h3004, 64'h0, 5'd8, 1'b1, 64'h114);
      bus.dresp_data = 64'h1122_3344_5566_7788;
`ifdef MEM_MISALIGN_TRAP_EN
      #1;
      checkOutput("ld_mis_noreq", {63'd0, bus.dreq_valid}, 64'd0);
      checkOutput("ld_mis_stall", {63'd0, stall_m}, 64'd0);
      @(negedge clk);
      checkOutput("ld_mis_flag",     {63'd0, out_misalign}, 64'd1);
      checkOutput("ld_mis_regwrite", {63'd0, out_regwrite}, 64'd0);
`else
      runMemOp(0, stalls, reqs);
      checkOutput("ld_mis_req_cycles", 64'(reqs), 64'd1);
      checkOutput("ld_mis_addr",       seen_addr, 64'h3004);
      checkOutput("ld_mis_result",     out_result, 64'h0000_0000_1122_3344);
      checkOutput("ld_mis_flag",       {63'd0, out_misalign}, 64'd0);
`endif
      clearInput();

      // Flush while idle kills the load before any request
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 64'h4000, 64'h0, 5'd9, 1'b1, 64'h118);
      flush = 1'b1;
      #1;
      checkOutput("fi_noreq", {63'd0, bus.dreq_valid}, 64'd0);
      checkOutput("fi_stall", {63'd0, stall_m}, 64'd0);
      @(negedge clk);
      checkOutput("fi_valid",    {63'd0, out_valid}, 64'd0);
      checkOutput("fi_regwrite", {63'd0, out_regwrite}, 64'd0);
      flush = 1'b0;
      clearInput();

      // Flush during WAIT_DATA: transaction completes, result is killed
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 64'h4008, 64'h0, 5'd9, 1'b1, 64'h11C);
      bus.dresp_addr_ok = 1'b1;
      #1;
      checkOutput("fw_req", {63'd0, bus.dreq_valid}, 64'd1);
      @(negedge clk);
      bus.dresp_addr_ok = 1'b0;
      flush = 1'b1;
      #1;
      checkOutput("fw_wait_noreq", {63'd0, bus.dreq_valid}, 64'd0);
      checkOutput("fw_wait_stall", {63'd0, stall_m}, 64'd1);
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = 64'h0000_0000_1234_5678;
      @(negedge clk);
      bus.dresp_data_ok = 1'b0;
      #1;
      checkOutput("fw_done_stall", {63'd0, stall_m}, 64'd0);
      @(negedge clk);
      checkOutput("fw_valid",    {63'd0, out_valid}, 64'd0);
      checkOutput("fw_regwrite", {63'd0, out_regwrite}, 64'd0);
      clearInput();
      applyStimulus(1'b0, 1'b0, 2'b11, 1'b0, 64'h55, 64'h0, 5'd3, 1'b1, 64'h120);
      #1;
      checkOutput("fw_idle_stall", {63'd0, stall_m}, 64'd0);
      @(negedge clk);
      checkOutput("fw_idle_result", out_result, 64'h55);
      checkOutput("fw_idle_valid",  {63'd0, out_valid}, 64'd1);
      clearInput();

      // Reset in WAIT_DATA abandons the transaction
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 64'h5000, 64'h0, 5'd4, 1'b1, 64'h124);
      bus.dresp_addr_ok = 1'b1;
      @(negedge clk);
      bus.dresp_addr_ok = 1'b0;
      #1;
      checkOutput("rw_wait_stall", {63'd0, stall_m}, 64'd1);
      #1;
      reset = 1'b1;
      clearInput();
      #1;
      checkOutput("rw_out_valid",  {63'd0, out_valid}, 64'd0);
      checkOutput("rw_out_result", out_result, 64'd0);
      checkOutput("rw_out_rd",     {59'd0, out_rd}, 64'd0);
      checkOutput("rw_out_pc",     out_pc, 64'd0);
      checkOutput("rw_stall",      {63'd0, stall_m}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      checkOutput("rw_late_stall", {63'd0, stall_m}, 64'd0);
      @(negedge clk);
      bus.dresp_data_ok = 1'b0;
      checkOutput("rw_late_valid", {63'd0, out_valid}, 64'd0);

      // Next load completes normally
      applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 64'h6002, 64'h0, 5'd10, 1'b1, 64'h128);
      bus.dresp_data = 64'h0000_0000_ABCD_0000;
      runMemOp(0, stalls, reqs);
      checkOutput("lh_stall_cycles", 64'(stalls), 64'd1);
      checkOutput("lh_result",       out_result, 64'hFFFF_FFFF_FFFF_ABCD);
      checkOutput("lh_rd",           {59'd0, out_rd}, 64'd10);
      checkOutput("lh_valid",        {63'd0, out_valid}, 64'd1);
      clearInput();
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the five-stage pipeline. It sits directly downstream of the execute stage and consumes its ALU result and store data. It turns loads and stores into data-bus transactions with an address/data handshake, and aligns and sign-extends load data. It registers the stage result toward writeback and asserts a stall to the hazard unit while a bus transaction is outstanding.

## Interface
Parameters:
- none; XLEN fixed at 64.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute output holds a live instruction.
- in_aluout  in  64  ALU result; this is the effective address for loads and stores.
- in_wdata  in  64  store data, unshifted.
- in_memread / in_memwrite  in  1 each  load / store; never both set.
- in_msize  in  2  00 byte, 01 half, 10 word, 11 dword.
- in_unsigned  in  1  zero-extend the load result.
- in_rd  in  5  destination register.
- in_regwrite  in  1  destination register write enable.
- in_pc  in  64  instruction PC.
- flush  in  1  from the hazard unit; kills the current input.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  64  request address.
- dreq_size  out  3  {0, in_msize}.
- dreq_strobe  out  8  byte-write mask; 0 for loads.
- dreq_data  out  64  lane-aligned store data.
- dresp_addr_ok  in  1  bus accepted the request.
- dresp_data_ok  in  1  bus completed the request.
- dresp_data  in  64  raw read data (full dword).
- stall_m  out  1  stage busy; upstream holds its inputs stable.
- out_valid, out_regwrite, out_misalign  out  1 each  registered stage result flags.
- out_result  out  64  registered writeback data.
- out_rd  out  5  registered destination register.
- out_pc  out  64  registered PC.

## Operation
- FSM states: IDLE, WAIT_DATA, DONE.
- IDLE with in_valid, not flush, memread|memwrite, and aligned:
  - dreq_valid=1 combinationally; stall_m=1.
  - addr_ok&data_ok in the same cycle → latch data, go to DONE.
  - addr_ok only → go to WAIT_DATA.
  - neither → stay in IDLE and keep requesting.
- WAIT_DATA: dreq_valid=0, stall_m=1. On data_ok, latch dresp_data into rdata_q and go to DONE.
- DONE: stall_m=0. The output register captures the result and the FSM returns to IDLE.
- Non-memory instruction in IDLE: no request, stall_m=0. Output captures in_aluout at the next edge.
- Store: off=addr[2:0].
  - dreq_data = in_wdata << 8·off.
  - dreq_strobe = size mask (0x01/0x03/0x0F/0xFF) << off.
  - out_result = in_aluout.
- Load: sh = rdata_q >> 8·off. Truncate to the size, then sign-extend, or zero-extend when in_unsigned is set.
- Misaligned means addr mod size ≠ 0. See Configuration.
- flush in IDLE: the next edge captures out_valid=0 and out_regwrite=0, and no request is issued.
- flush while in WAIT_DATA: the transaction still completes because the bus cannot cancel. A kill flag is set, and DONE captures out_valid=0 and out_regwrite=0.
- Out-of-valid input (in_valid=0): captures out_valid=0; no request.

## Timing
- Reset value of every output register is 0 (out_valid, out_result, out_rd, out_regwrite, out_pc, out_misalign), and the FSM is in IDLE.
- Combinational outputs after reset: dreq_valid=0, stall_m=0.
- Async reset during WAIT_DATA abandons the transaction immediately. A data_ok arriving after reset is ignored.
- Non-memory instruction latency: 1 cycle to out_*.
- Memory operation with zero-wait bus: stall_m is high for 1 cycle, then DONE.
  - Result is visible on out_* 2 edges after issue.
  - Each added bus wait cycle adds 1.
- dreq_addr, dreq_size, dreq_strobe and dreq_data are driven from the held inputs. They are stable for as long as dreq_valid is high.
- No new request is issued while in WAIT_DATA or DONE.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned load or store issues no request and does not stall.
  - The next edge captures out_misalign=1 and out_regwrite=0.
- MEM_MISALIGN_TRAP_EN undefined:
  - out_misalign is tied to 0.
  - The address is issued as-is and the byte lanes come from addr[2:0]. Lanes that cross the dword boundary are dropped.

## Test plan
- ADD result 0x1234 with rd=5 → out_result=0x1234 and out_rd=5 one edge later; stall_m is never high.
- LB at 0x1003 with zero-wait bus returning 0x0000_0000_8000_0000 → out_result=0xFFFF_FFFF_FFFF_FF80.
  - stall_m high for exactly 1 cycle.
  - Same case with in_unsigned=1 gives 0x80.
- SW at 0x2004 with data 0xDEADBEEF → dreq_strobe=0xF0 and dreq_data=0xDEADBEEF_0000_0000. With 3 data_ok wait cycles, stall_m is high for 4 cycles.
- LD at 0x3004 → with MEM_MISALIGN_TRAP_EN: out_misalign=1, no dreq_valid, out_regwrite=0. Without the macro: a request is issued to 0x3004.
- LW with addr_ok then flush in WAIT_DATA, data_ok 2 cycles later → out_valid=0, out_regwrite=0; the FSM returns to IDLE.
- Reset asserted in WAIT_DATA → all outputs 0 at once. A late data_ok is ignored, and the next load completes normally.
